// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: pipeline-register mode bit positions, GPR address width,
// and the hazard-controller state encoding.
package hazard_ctrl_pkg;

  localparam int GPR_ADDR_SPACE = 5;

  // A pipeline register's mode carries one flush bit and one stall bit.
  localparam int MODE_FLUSH_BIT = 0;
  localparam int MODE_STALL_BIT = 1;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RUN   = 2'b00;
  localparam mode_t MODE_FLUSH = mode_t'(1 << MODE_FLUSH_BIT);
  localparam mode_t MODE_STALL = mode_t'(1 << MODE_STALL_BIT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MDU_WAIT = 2'b01,
    ST_MEM_WAIT = 2'b10
  } hz_state_e;

  // An ID source matches EXE's destination only if that source is actually read.
  function automatic logic src_hit(input logic [GPR_ADDR_SPACE-1:0] src,
                                   input logic                      re,
                                   input logic [GPR_ADDR_SPACE-1:0] rd);
    return re && (src == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory and MDU stalls, branch flush and load-use interlock,
// plus saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [GPR_ADDR_SPACE-1:0] id_rs1_addr_i,
  input  logic [GPR_ADDR_SPACE-1:0] id_rs2_addr_i,
  input  logic                      id_rs1_re_i,
  input  logic                      id_rs2_re_i,
  input  logic [GPR_ADDR_SPACE-1:0] exe_rd_addr_i,
  input  logic                      exe_rd_we_i,
  input  logic                      exe_mem_re_i,
  input  logic                      exe_branch_taken_i,
  input  logic                      exe_mdu_req_i,
  input  logic                      mdu_done_i,
  input  logic                      mem_req_i,
  input  logic                      mem_ready_i,
  output logic                      pc_stall_o,
  output logic [1:0]                if_id_mode_o,
  output logic [1:0]                id_exe_mode_o,
  output logic [1:0]                exe_mem_mode_o,
  output logic [1:0]                mem_wb_mode_o,
  output logic                      mdu_start_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  hz_state_e state_q, state_d;
  hz_state_e saved_q, saved_d;
  logic      done_q, done_d;

  logic mem_stall;
  logic mdu_stall;
  logic mdu_start;
  logic branch_flush;
  logic load_use;
  logic mdu_pending;

  assign mem_stall = mem_req_i && !mem_ready_i;

  // An MDU operation is outstanding either directly or behind a memory wait.
  assign mdu_pending = (state_q == ST_MDU_WAIT) ||
                       ((state_q == ST_MEM_WAIT) && (saved_q == ST_MDU_WAIT));

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    done_d    = done_q;
    mdu_stall = 1'b0;
    mdu_start = 1'b0;

    if (mem_stall) begin
      state_d = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) saved_d = state_q;
      if (mdu_pending) done_d = done_q | mdu_done_i;
    end else if (state_q == ST_MDU_WAIT) begin
      if (mdu_done_i || done_q) begin
        state_d = ST_RUN;
        done_d  = 1'b0;
      end else begin
        mdu_stall = 1'b1;
      end
    end else if (mdu_pending) begin
      // Leaving a memory wait that interrupted the MDU: keep holding EXE for one
      // more cycle so a done captured meanwhile is consumed back in MDU_WAIT.
      mdu_stall = 1'b1;
      state_d   = ST_MDU_WAIT;
      done_d    = done_q | mdu_done_i;
    end else begin
      state_d = ST_RUN;
      if (exe_mdu_req_i) begin
        mdu_start = 1'b1;
        mdu_stall = 1'b1;
        state_d   = ST_MDU_WAIT;
      end
    end
  end

  assign branch_flush = exe_branch_taken_i && !mem_stall && !mdu_stall;

  assign load_use = !mem_stall && !mdu_stall && !exe_branch_taken_i &&
                    exe_mem_re_i && exe_rd_we_i && (exe_rd_addr_i != '0) &&
                    (src_hit(id_rs1_addr_i, id_rs1_re_i, exe_rd_addr_i) ||
                     src_hit(id_rs2_addr_i, id_rs2_re_i, exe_rd_addr_i));

  // Reset gates the control outputs so a held request cannot leak a stall or launch.
  always_comb begin
    pc_stall_o     = 1'b0;
    if_id_mode_o   = MODE_RUN;
    id_exe_mode_o  = MODE_RUN;
    exe_mem_mode_o = MODE_RUN;
    mem_wb_mode_o  = MODE_RUN;
    mdu_start_o    = 1'b0;

    if (rst_ni) begin
      mdu_start_o = mdu_start;
      if (mem_stall) begin
        pc_stall_o     = 1'b1;
        if_id_mode_o   = MODE_STALL;
        id_exe_mode_o  = MODE_STALL;
        exe_mem_mode_o = MODE_STALL;
        mem_wb_mode_o  = MODE_FLUSH;
      end else if (mdu_stall) begin
        pc_stall_o     = 1'b1;
        if_id_mode_o   = MODE_STALL;
        id_exe_mode_o  = MODE_STALL;
        exe_mem_mode_o = MODE_FLUSH;
      end else if (branch_flush) begin
        if_id_mode_o   = MODE_FLUSH;
        id_exe_mode_o  = MODE_FLUSH;
      end else if (load_use) begin
        pc_stall_o     = 1'b1;
        if_id_mode_o   = MODE_STALL;
        id_exe_mode_o  = MODE_FLUSH;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      saved_q <= ST_RUN;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      done_q  <= done_d;
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (pc_stall_o),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (branch_flush),
    .cnt_o  (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, MDU, memory-wait, saturation and async reset.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CW = 32;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b1;
  logic [GPR_ADDR_SPACE-1:0] id_rs1_addr_i, id_rs2_addr_i, exe_rd_addr_i;
  logic                      id_rs1_re_i, id_rs2_re_i, exe_rd_we_i, exe_mem_re_i;
  logic                      exe_branch_taken_i, exe_mdu_req_i, mdu_done_i;
  logic                      mem_req_i, mem_ready_i;
  logic                      pc_stall_o, mdu_start_o;
  logic [1:0]                if_id_mode_o, id_exe_mode_o, exe_mem_mode_o, mem_wb_mode_o;
  logic [CW-1:0]             stall_cnt_o, flush_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .id_rs1_addr_i      (id_rs1_addr_i),
    .id_rs2_addr_i      (id_rs2_addr_i),
    .id_rs1_re_i        (id_rs1_re_i),
    .id_rs2_re_i        (id_rs2_re_i),
    .exe_rd_addr_i      (exe_rd_addr_i),
    .exe_rd_we_i        (exe_rd_we_i),
    .exe_mem_re_i       (exe_mem_re_i),
    .exe_branch_taken_i (exe_branch_taken_i),
    .exe_mdu_req_i      (exe_mdu_req_i),
    .mdu_done_i         (mdu_done_i),
    .mem_req_i          (mem_req_i),
    .mem_ready_i        (mem_ready_i),
    .pc_stall_o         (pc_stall_o),
    .if_id_mode_o       (if_id_mode_o),
    .id_exe_mode_o      (id_exe_mode_o),
    .exe_mem_mode_o     (exe_mem_mode_o),
    .mem_wb_mode_o      (mem_wb_mode_o),
    .mdu_start_o        (mdu_start_o),
    .stall_cnt_o        (stall_cnt_o),
    .flush_cnt_o        (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_modes(input string tag, input logic pc, input logic [1:0] if_id,
                             input logic [1:0] id_exe, input logic [1:0] exe_mem,
                             input logic [1:0] mem_wb);
    check({tag, "_pc"},      64'(pc_stall_o),     64'(pc));
    check({tag, "_if_id"},   64'(if_id_mode_o),   64'(if_id));
    check({tag, "_id_exe"},  64'(id_exe_mode_o),  64'(id_exe));
    check({tag, "_exe_mem"}, 64'(exe_mem_mode_o), 64'(exe_mem));
    check({tag, "_mem_wb"},  64'(mem_wb_mode_o),  64'(mem_wb));
  endtask

  task automatic idle();
    id_rs1_addr_i = '0; id_rs2_addr_i = '0; exe_rd_addr_i = '0;
    id_rs1_re_i = 0; id_rs2_re_i = 0; exe_rd_we_i = 0; exe_mem_re_i = 0;
    exe_branch_taken_i = 0; exe_mdu_req_i = 0; mdu_done_i = 0;
    mem_req_i = 0; mem_ready_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic load_use_x5();
    idle();
    exe_mem_re_i = 1; exe_rd_we_i = 1; exe_rd_addr_i = 5'd5;
    id_rs1_addr_i = 5'd3; id_rs1_re_i = 1;
    id_rs2_addr_i = 5'd5; id_rs2_re_i = 1;
  endtask

  initial begin
    idle();
    #1 rst_ni = 1'b0;
    #3;
    check_modes("rst", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    check("rst_start", 64'(mdu_start_o), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt_o), 64'd0);
    do_reset();

    // Load-use on rs2=x5, then the hazard clears.
    load_use_x5();
    #2 check_modes("lu", 1, 2'b10, 2'b01, 2'b00, 2'b00);
    tick();
    check("lu_stall_cnt", 64'(stall_cnt_o), 64'd1);
    check("lu_flush_cnt", 64'(flush_cnt_o), 64'd0);
    idle();
    #2 check_modes("lu_gone", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();

    // Load to x0 read by rs2: never a hazard.
    load_use_x5();
    exe_rd_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
    #2 check_modes("lu_x0", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();

    // Matching sources that are not read: no hazard.
    load_use_x5();
    id_rs1_addr_i = 5'd5; id_rs1_re_i = 0; id_rs2_re_i = 0;
    #2 check_modes("lu_nore", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();

    // Match through rs1 only.
    load_use_x5();
    id_rs1_addr_i = 5'd5; id_rs2_re_i = 0;
    #2 check_modes("lu_rs1", 1, 2'b10, 2'b01, 2'b00, 2'b00);
    tick();
    check("lu_rs1_cnt", 64'(stall_cnt_o), 64'd2);

    // Branch overrides load-use.
    load_use_x5();
    exe_branch_taken_i = 1;
    #2 check_modes("br_lu", 0, 2'b01, 2'b01, 2'b00, 2'b00);
    tick();
    check("br_flush_cnt", 64'(flush_cnt_o), 64'd1);
    check("br_stall_cnt", 64'(stall_cnt_o), 64'd2);

    // Memory stall masks branch and MDU launch.
    idle();
    exe_branch_taken_i = 1; exe_mdu_req_i = 1; mem_req_i = 1; mem_ready_i = 0;
    #2 check_modes("mem_mask", 1, 2'b10, 2'b10, 2'b10, 2'b01);
    check("mem_mask_start", 64'(mdu_start_o), 64'd0);
    tick();
    check("mem_mask_flush", 64'(flush_cnt_o), 64'd1);
    check("mem_mask_stall", 64'(stall_cnt_o), 64'd3);
    idle();
    mem_req_i = 1; mem_ready_i = 1;
    #2 check_modes("mem_ready", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    tick();
    check("mem_ret_run", 64'(dut.state_q), 64'(ST_RUN));

    // MDU op with done four cycles after launch.
    do_reset();
    exe_mdu_req_i = 1;
    #2 check_modes("mdu_c0", 1, 2'b10, 2'b10, 2'b01, 2'b00);
    check("mdu_c0_start", 64'(mdu_start_o), 64'd1);
    tick();
    for (int i = 1; i < 4; i++) begin
      #2 check_modes($sformatf("mdu_c%0d", i), 1, 2'b10, 2'b10, 2'b01, 2'b00);
      check($sformatf("mdu_c%0d_start", i), 64'(mdu_start_o), 64'd0);
      tick();
    end
    mdu_done_i = 1;
    #2 check_modes("mdu_rel", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    check("mdu_rel_start", 64'(mdu_start_o), 64'd0);
    tick();
    check("mdu_stall_cnt", 64'(stall_cnt_o), 64'd4);
    idle();
    mdu_done_i = 1;
    #2 check("run_done_ign", 64'(pc_stall_o), 64'd0);
    tick();
    check("run_done_state", 64'(dut.state_q), 64'(ST_RUN));

    // Memory wait of three cycles inside MDU_WAIT, done in the second.
    do_reset();
    exe_mdu_req_i = 1;
    #2 check("mw_start", 64'(mdu_start_o), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_req_i = 1; mem_ready_i = 0; mdu_done_i = (i == 1);
      #2 check_modes($sformatf("mw%0d", i), 1, 2'b10, 2'b10, 2'b10, 2'b01);
      check($sformatf("mw%0d_start", i), 64'(mdu_start_o), 64'd0);
      tick();
      check($sformatf("mw%0d_state", i), 64'(dut.state_q), 64'(ST_MEM_WAIT));
    end
    mdu_done_i = 0; mem_ready_i = 1;
    #2 check_modes("mw_exit", 1, 2'b10, 2'b10, 2'b01, 2'b00);
    tick();
    check("mw_back_mdu", 64'(dut.state_q), 64'(ST_MDU_WAIT));
    mem_req_i = 0; mem_ready_i = 0;
    #2 check_modes("mw_rel", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    check("mw_rel_start", 64'(mdu_start_o), 64'd0);
    tick();
    check("mw_run", 64'(dut.state_q), 64'(ST_RUN));
    check("mw_stall_cnt", 64'(stall_cnt_o), 64'd5);
    idle();

    // Saturation of both counters.
    do_reset();
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFD;
    force dut.u_flush_cnt.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.cnt_q;
    release dut.u_flush_cnt.cnt_q;
    check("sat_preload", 64'(stall_cnt_o), 64'hFFFF_FFFD);
    mem_req_i = 1; mem_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sat_stall%0d", i), 64'(stall_cnt_o),
            (i == 0) ? 64'hFFFF_FFFE : 64'hFFFF_FFFF);
    end
    idle();
    mem_req_i = 1; mem_ready_i = 1;
    tick();
    idle();
    exe_branch_taken_i = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_flush%0d", i), 64'(flush_cnt_o), 64'hFFFF_FFFF);
    end
    check("sat_stall_hold", 64'(stall_cnt_o), 64'hFFFF_FFFF);

    // Asynchronous reset in the middle of an MDU wait.
    do_reset();
    exe_mdu_req_i = 1;
    tick();
    #2 check("ar_in_mdu", 64'(dut.state_q), 64'(ST_MDU_WAIT));
    rst_ni = 1'b0;
    #1;
    check_modes("ar", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    check("ar_start", 64'(mdu_start_o), 64'd0);
    check("ar_state", 64'(dut.state_q), 64'(ST_RUN));
    check("ar_stall_cnt", 64'(stall_cnt_o), 64'd0);
    idle();
    tick();
    rst_ni = 1'b1;
    #2 check_modes("ar_after", 0, 2'b00, 2'b00, 2'b00, 2'b00);
    check("ar_after_start", 64'(mdu_start_o), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL be clocked by clk_i, a single clock, and reset by rst_ni, asynchronous and active-low.
REQ-002 Parameter: CNT_WIDTH, default 32, width of the performance counters.
REQ-003 Port: clk_i  in  1  clock.
REQ-004 Port: rst_ni  in  1  async active-low reset.
REQ-005 Port: id_rs1_addr_i, id_rs2_addr_i  in  `GPR_ADDR_SPACE each  source registers of the instruction in ID.
REQ-006 Port: id_rs1_re_i, id_rs2_re_i  in  1 each  source-read enables in ID.
REQ-007 Port: exe_rd_addr_i  in  `GPR_ADDR_SPACE  destination register in EXE.
REQ-008 Port: exe_rd_we_i, exe_mem_re_i  in  1 each  EXE writes rd / EXE is a load.
REQ-009 Port: exe_branch_taken_i  in  1  EXE resolved a taken branch or jump.
REQ-010 Port: exe_mdu_req_i  in  1  EXE holds a multi-cycle mul/div instruction.
REQ-011 Port: mdu_done_i  in  1  one-cycle pulse, MDU result valid.
REQ-012 Port: mem_req_i, mem_ready_i  in  1 each  MEM stage data access pending / memory accepted.
REQ-013 Port: pc_stall_o  out  1  hold the PC.
REQ-014 Port: if_id_mode_o, id_exe_mode_o, exe_mem_mode_o, mem_wb_mode_o  out  2 each  bit0 = flush, bit1 = stall.
REQ-015 Port: mdu_start_o  out  1  one-cycle MDU launch pulse.
REQ-016 Port: stall_cnt_o, flush_cnt_o  out  CNT_WIDTH each  performance counters.

Function
REQ-017 The FSM SHALL have three states: RUN, MDU_WAIT and MEM_WAIT.
REQ-018 All mode and stall outputs SHALL be combinational from the current state and inputs, with zero-cycle latency.
REQ-019 Mode 2'b11 SHALL never be driven; an unasserted stage SHALL get 2'b00.
REQ-020 Memory stall (highest priority): when mem_req_i=1 and mem_ready_i=0, the block SHALL assert pc_stall_o, stall IF_ID, ID_EXE and EXE_MEM, flush MEM_WB, and enter or stay in MEM_WAIT.
REQ-021 A memory stall SHALL mask branch flush, load-use detection and mdu_start_o.
REQ-022 In MEM_WAIT, when mem_ready_i=1 the block SHALL drive no memory stall that cycle and return to the saved prior state (RUN or MDU_WAIT).
REQ-023 MDU launch: in RUN with exe_mdu_req_i=1 and no memory stall, the block SHALL pulse mdu_start_o for exactly one cycle, enter MDU_WAIT, and assert MDU stall that cycle.
REQ-024 MDU stall SHALL assert pc_stall_o, stall IF_ID and ID_EXE, and flush EXE_MEM.
REQ-025 In MDU_WAIT the block SHALL hold the MDU stall until a done has been seen; on that cycle it SHALL release the stall and go to RUN.
REQ-026 If mdu_done_i arrives during MEM_WAIT, a sticky done flag SHALL be set and consumed on return to MDU_WAIT.
REQ-027 mdu_done_i SHALL be ignored in RUN; a same-cycle done with the start is not supported.
REQ-028 Branch: when exe_branch_taken_i=1 with no memory or MDU stall, the block SHALL flush IF_ID and ID_EXE and SHALL NOT assert pc_stall_o.
REQ-029 A branch flush SHALL override load-use.
REQ-030 Load-use: when exe_mem_re_i=1, exe_rd_we_i=1, exe_rd_addr_i≠0 and an enabled ID source equals exe_rd_addr_i, the block SHALL assert pc_stall_o, stall IF_ID and flush ID_EXE.
REQ-031 A read of x0 SHALL never cause a load-use hazard.
REQ-032 stall_cnt_o SHALL increment every cycle pc_stall_o=1.
REQ-033 flush_cnt_o SHALL increment every branch flush.
REQ-034 Both counters SHALL saturate at all-ones and SHALL never wrap.

Reset
REQ-035 On rst_ni=0 the block SHALL immediately enter RUN and clear the saved state, the sticky done flag and both counters.
REQ-036 During reset all modes SHALL read 2'b00 and pc_stall_o and mdu_start_o SHALL read 0.
REQ-037 A reset asserted mid-MDU or mid-MEM_WAIT SHALL abandon the operation without emitting mdu_start_o.

Structure
REQ-038 The mode bit positions (Flush=bit0, Stall=bit1) and the FSM state encodings SHALL live in the shared defines header used by the pipeline registers.
REQ-039 The two counters SHALL be instances of one sub-module, sat_counter, parameterised by CNT_WIDTH.

Verification
REQ-040 The bench SHALL cover: load to x5 in EXE while ID reads rs2=x5 -> pc_stall_o=1, if_id=2'b10, id_exe=2'b01 for one cycle; the same with rd=x0 -> no stall.
REQ-041 The bench SHALL cover: branch taken while a load-use hazard is present -> if_id=id_exe=2'b01, pc_stall_o=0, flush_cnt_o +1.
REQ-042 The bench SHALL cover: exe_mdu_req_i with done 4 cycles later -> mdu_start_o high 1 cycle, 4 stall cycles, exe_mem=2'b01, stall_cnt_o=4.
REQ-043 The bench SHALL cover: mem_ready_i low 3 cycles during MDU_WAIT with done arriving in cycle 2 -> MEM_WAIT, then return to MDU_WAIT, then release on the next cycle; mem_wb=2'b01 for 3 cycles.
REQ-044 The bench SHALL cover: counters preloaded near all-ones via a force -> they hold at all-ones with no wrap.
REQ-045 The bench SHALL cover: rst_ni low in MDU_WAIT -> all outputs 0 and the state is RUN asynchronously.
